// File: rtl/register_file.sv
// register_file: parameterised general-purpose register file with two
// combinational read ports, one write port, link (call) writeback redirect,
// write-through bypass, a hardwired-zero register 0 and a committed-write
// counter.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          asynchronous active-low reset; clears registers and counter
//   rs_addr      read port A index
//   rt_addr      read port B index
//   rs_data      read port A data (combinational, bypassed)
//   rt_data      read port B data (combinational, bypassed)
//   reg_write    write enable for the current cycle
//   link         redirect the write to LINK_REG instead of write_addr
//   write_addr   write index when link is low
//   write_data   writeback value
//   write_count  committed-write counter, wraps modulo 256
module register_file #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned LINK_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              reg_write,
    input  logic              link,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [7:0]        write_count
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_IDX = LINK_REG[ADDR_W-1:0];

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [ADDR_W-1:0] eff_addr;
    logic              commit;

    always_comb begin
        eff_addr = link ? LINK_IDX : write_addr;
        // Writes aimed at register 0 are dropped and do not count.
        commit   = reg_write && (eff_addr != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            write_count <= '0;
        end else if (commit) begin
            regs[eff_addr] <= write_data;
            write_count    <= write_count + 8'd1;
        end
    end

    // Bypass is purely combinational, so it still applies while reset is
    // held; the commit test already excludes index 0, which keeps reads of
    // register 0 at zero even with a pending write there.
    always_comb begin
        if (rs_addr == '0)
            rs_data = '0;
        else if (commit && (eff_addr == rs_addr))
            rs_data = write_data;
        else
            rs_data = regs[rs_addr];

        if (rt_addr == '0)
            rt_data = '0;
        else if (commit && (eff_addr == rt_addr))
            rt_data = write_data;
        else
            rt_data = regs[rt_addr];
    end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed self-checking bench for register_file.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        reg_write;
    logic        link;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [7:0]  write_count;

    int errors = 0;
    int checks = 0;

    register_file #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .LINK_REG (31)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .reg_write   (reg_write),
        .link        (link),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .write_count (write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        reg_write  = 1'b1;
        link       = 1'b0;
        write_addr = a;
        write_data = d;
        tick();
        reg_write  = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        rs_addr    = '0;
        rt_addr    = '0;
        reg_write  = 1'b0;
        link       = 1'b0;
        write_addr = '0;
        write_data = '0;
        #12;

        // Reset state: every index reads 0 on both ports.
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            #1;
            check($sformatf("reset_rs[%0d]", i), rs_data, 32'h0);
            check($sformatf("reset_rt[%0d]", 31 - i), rt_data, 32'h0);
        end
        check("reset_count", {24'h0, write_count}, 32'h0);

        @(negedge clk);
        rst = 1'b1;
        #1;

        // Basic write then read.
        write_reg(5'd5, 32'hDEADBEEF);
        rs_addr = 5'd5;
        rt_addr = 5'd5;
        #1;
        check("wr5_rs", rs_data, 32'hDEADBEEF);
        check("wr5_rt", rt_data, 32'hDEADBEEF);
        check("wr5_count", {24'h0, write_count}, 32'd1);

        // Write to register 0 is suppressed, no bypass onto index 0.
        reg_write  = 1'b1;
        write_addr = 5'd0;
        write_data = 32'hFFFFFFFF;
        rs_addr    = 5'd0;
        #1;
        check("r0_bypass_rs", rs_data, 32'h0);
        tick();
        reg_write = 1'b0;
        #1;
        check("r0_after_rs", rs_data, 32'h0);
        check("r0_count", {24'h0, write_count}, 32'd1);

        // Link writeback redirects to register 31.
        reg_write  = 1'b1;
        link       = 1'b1;
        write_addr = 5'd7;
        write_data = 32'h00000104;
        tick();
        reg_write = 1'b0;
        link      = 1'b0;
        rs_addr   = 5'd31;
        rt_addr   = 5'd7;
        #1;
        check("link_r31", rs_data, 32'h00000104);
        check("link_r7", rt_data, 32'h0);
        check("link_count", {24'h0, write_count}, 32'd2);

        // Link with reg_write low writes nothing.
        link       = 1'b1;
        write_data = 32'hCAFEF00D;
        tick();
        link = 1'b0;
        #1;
        check("link_nowr_r31", rs_data, 32'h00000104);
        check("link_nowr_count", {24'h0, write_count}, 32'd2);

        // Same-cycle bypass on both ports.
        reg_write  = 1'b1;
        write_addr = 5'd9;
        write_data = 32'h12345678;
        rs_addr    = 5'd9;
        rt_addr    = 5'd9;
        #1;
        check("bypass_rs", rs_data, 32'h12345678);
        check("bypass_rt", rt_data, 32'h12345678);
        rt_addr = 5'd5;
        #1;
        check("bypass_other_rt", rt_data, 32'hDEADBEEF);
        tick();
        reg_write = 1'b0;
        #1;
        check("stored9_rs", rs_data, 32'h12345678);
        check("bypass_count", {24'h0, write_count}, 32'd3);

        // Back-to-back writes to one index keep the last value.
        write_reg(5'd10, 32'h00000001);
        write_reg(5'd10, 32'h00000002);
        rs_addr = 5'd10;
        #1;
        check("last_wins", rs_data, 32'h00000002);
        check("b2b_count", {24'h0, write_count}, 32'd5);

        // Counter wrap: 250 more writes -> 255, one more -> 0.
        for (int i = 0; i < 250; i++) begin
            write_reg(5'd3, 32'(i));
        end
        #1;
        check("count_255", {24'h0, write_count}, 32'd255);
        write_reg(5'd3, 32'hA5A5A5A5);
        rs_addr = 5'd3;
        #1;
        check("count_wrap", {24'h0, write_count}, 32'd0);
        check("wrap_r3", rs_data, 32'hA5A5A5A5);

        // Asynchronous reset between edges clears immediately.
        @(negedge clk);
        #2;
        rst     = 1'b0;
        rs_addr = 5'd5;
        rt_addr = 5'd31;
        #1;
        check("async_rst_r5", rs_data, 32'h0);
        check("async_rst_r31", rt_data, 32'h0);
        check("async_rst_count", {24'h0, write_count}, 32'd0);

        // Bypass still applies during reset, but the write is discarded.
        reg_write  = 1'b1;
        write_addr = 5'd9;
        write_data = 32'h000000AA;
        rs_addr    = 5'd9;
        #1;
        check("rst_bypass_rs", rs_data, 32'h000000AA);
        tick();
        reg_write = 1'b0;
        #1;
        check("rst_discard_r9", rs_data, 32'h0);
        check("rst_discard_count", {24'h0, write_count}, 32'd0);

        // First write after release commits on the first edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        write_reg(5'd12, 32'h00000055);
        rs_addr = 5'd12;
        #1;
        check("post_rst_r12", rs_data, 32'h00000055);
        check("post_rst_count", {24'h0, write_count}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_W, default 32, register and data width in bits.
REQ-002 Parameter ADDR_W, default 5, register index width; register count = 2**ADDR_W.
REQ-003 Parameter LINK_REG, default 31, index written on link (call) writeback.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 rs_addr  input  ADDR_W  read port A index.
REQ-007 rt_addr  input  ADDR_W  read port B index.
REQ-008 rs_data  output  DATA_W  read port A data.
REQ-009 rt_data  output  DATA_W  read port B data.
REQ-010 reg_write  input  1  write enable for the current cycle.
REQ-011 link  input  1  link writeback; overrides write_addr with LINK_REG.
REQ-012 write_addr  input  ADDR_W  write index when link=0.
REQ-013 write_data  input  DATA_W  writeback value from the writeback select mux.
REQ-014 write_count  output  8  count of committed writes, wraps modulo 256.

Function
REQ-015 Effective write index SHALL be LINK_REG when link=1, else write_addr.
REQ-016 Write SHALL commit on the rising clk edge when reg_write=1 and effective index != 0; register 0 SHALL never change.
REQ-017 link=1 with reg_write=0 SHALL cause no write.
REQ-018 Reads SHALL be combinational: rs_data = reg[rs_addr], rt_data = reg[rt_addr], zero latency.
REQ-019 Index 0 SHALL always read 0 on both ports, regardless of pending writes.
REQ-020 Write-through bypass: if reg_write=1, effective index != 0, and it equals a read index in the same cycle, that port SHALL output write_data instead of the stored value.
REQ-021 Both ports reading the same index SHALL return identical data, bypass included.
REQ-022 Write latency: value written at edge N SHALL be visible from storage for all cycles after edge N.
REQ-023 write_count SHALL increment by 1 on each committed write (REQ-016) and not on suppressed writes to register 0; 255 + 1 SHALL wrap to 0.
REQ-024 Consecutive writes to the same index SHALL leave the last value; no write merging or reordering.
REQ-025 No X SHALL propagate to outputs from any valid in-range index after reset.

Reset
REQ-026 While rst=0, all registers SHALL clear to 0 and write_count SHALL be 0, asynchronously without waiting for clk.
REQ-027 A write coinciding with rst=0 SHALL be discarded; reset wins.
REQ-028 Reset asserted mid-operation SHALL clear all state immediately; rs_data/rt_data SHALL read 0 for stored values, but bypass (REQ-020) SHALL still apply combinationally.
REQ-029 First write SHALL commit on the first rising edge where rst=1 and reg_write=1.

Verification
REQ-030 Reset, then read all 32 indices on both ports -> all 0, write_count=0.
REQ-031 reg_write=1, write_addr=5, write_data=0xDEADBEEF, clock; next cycle rs_addr=5 -> rs_data=0xDEADBEEF, write_count=1.
REQ-032 reg_write=1, write_addr=0, write_data=0xFFFFFFFF, clock; rs_addr=0 -> rs_data=0, write_count unchanged.
REQ-033 reg_write=1, link=1, write_addr=7, write_data=0x00000104, clock -> reg31=0x00000104, reg7 unchanged.
REQ-034 Same cycle: reg_write=1, write_addr=9, write_data=0x12345678, rs_addr=rt_addr=9 -> both ports 0x12345678 before the edge.
REQ-035 256 committed writes -> write_count wraps to 0; rst=0 between clock edges -> all registers and write_count 0 immediately.
